// File: rtl/wav_stream_packer.sv
// Parses a canonical 44-byte RIFF/WAVE header from a byte stream, then packs
// little-endian PCM bytes into left-justified samples with a valid/ready output.
//
// state  | meaning
// IDLE   | after reset, waiting for start; bytes ignored
// HEADER | consuming and checking header bytes 0..43
// DATA   | assembling samples until the data length is consumed
// DONE   | all data consumed; only the pending output handshake completes
// ERR    | header rejected; bytes ignored until the next start
module wav_stream_packer #(
    parameter int OUT_W  = 32,
    parameter int MAX_CH = 2,
    localparam int CH_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_en,
    input  logic [7:0]        in_byte,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [31:0]       sample_rate,
    output logic [15:0]       num_ch,
    output logic [15:0]       bits_ps,
    output logic              hdr_ok,
    output logic              hdr_err,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [2:0] {IDLE, HEADER, DATA, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic [5:0]        hdr_cnt;
    logic              hdr_bad;
    logic [31:0]       data_len;
    logic [31:0]       data_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       samp_lo;
    logic [CH_W-1:0]   ch_cnt;

    logic              hdr_byte, hdr_last, dat_byte, samp_last, samp_done;
    logic              chk_en, byte_bad, fmt_bad, xfer;
    logic [7:0]        chk_val;
    logic [1:0]        last_idx;
    logic [31:0]       samp_full, just_sh;
    logic [OUT_W-1:0]  out_val;

    assign hdr_byte  = (state == HEADER) && in_en;
    assign hdr_last  = hdr_byte && (hdr_cnt == 6'd43);
    assign dat_byte  = (state == DATA) && in_en;
    assign last_idx  = 2'(bits_ps[5:3] - 3'd1);
    assign samp_last = (byte_idx == last_idx);
    assign samp_done = dat_byte && samp_last;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        chk_en  = 1'b1;
        chk_val = 8'h00;
        case (hdr_cnt)
            6'd0:  chk_val = 8'h52;
            6'd1:  chk_val = 8'h49;
            6'd2:  chk_val = 8'h46;
            6'd3:  chk_val = 8'h46;
            6'd8:  chk_val = 8'h57;
            6'd9:  chk_val = 8'h41;
            6'd10: chk_val = 8'h56;
            6'd11: chk_val = 8'h45;
            6'd12: chk_val = 8'h66;
            6'd13: chk_val = 8'h6d;
            6'd14: chk_val = 8'h74;
            6'd15: chk_val = 8'h20;
            6'd20: chk_val = 8'h01;
            6'd21: chk_val = 8'h00;
            6'd36: chk_val = 8'h64;
            6'd37: chk_val = 8'h61;
            6'd38: chk_val = 8'h74;
            6'd39: chk_val = 8'h61;
            default: chk_en = 1'b0;
        endcase
    end

    assign byte_bad = hdr_byte && chk_en && (in_byte != chk_val);
    assign fmt_bad  = (num_ch == 16'd0) || (num_ch > 16'(MAX_CH)) ||
                      !((bits_ps == 16'd8) || (bits_ps == 16'd16) ||
                        (bits_ps == 16'd24) || (bits_ps == 16'd32)) ||
                      (bits_ps > 16'(OUT_W));

    // Sample value with the incoming byte merged in, then left-justified.
    always_comb begin
        samp_full = {8'h00, samp_lo};
        samp_full[{byte_idx, 3'b000} +: 8] = in_byte;
        if (bits_ps == 16'd8)
            samp_full[7] = ~samp_full[7];
        just_sh = samp_full << (6'd32 - bits_ps[5:0]);
        out_val = OUT_W'(just_sh >> (32 - OUT_W));
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = HEADER;
        end else begin
            case (state)
                HEADER: if (hdr_last) begin
                    if (hdr_bad || fmt_bad)
                        state_nx = ERR;
                    else if ({in_byte, data_len[23:0]} == 32'd0)
                        state_nx = DONE;
                    else
                        state_nx = DATA;
                end
                DATA: if (dat_byte && (data_cnt == data_len - 32'd1))
                    state_nx = DONE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || start) begin
            hdr_cnt     <= '0;
            hdr_bad     <= 1'b0;
            data_len    <= '0;
            data_cnt    <= '0;
            byte_idx    <= '0;
            samp_lo     <= '0;
            ch_cnt      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            sample_rate <= '0;
            num_ch      <= '0;
            bits_ps     <= '0;
            hdr_ok      <= 1'b0;
            hdr_err     <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (hdr_byte) begin
                hdr_cnt <= hdr_cnt + 6'd1;
                if (byte_bad)
                    hdr_bad <= 1'b1;
                case (hdr_cnt)
                    6'd22: num_ch[7:0]       <= in_byte;
                    6'd23: num_ch[15:8]      <= in_byte;
                    6'd24: sample_rate[7:0]  <= in_byte;
                    6'd25: sample_rate[15:8] <= in_byte;
                    6'd26: sample_rate[23:16] <= in_byte;
                    6'd27: sample_rate[31:24] <= in_byte;
                    6'd34: bits_ps[7:0]      <= in_byte;
                    6'd35: bits_ps[15:8]     <= in_byte;
                    6'd40: data_len[7:0]     <= in_byte;
                    6'd41: data_len[15:8]    <= in_byte;
                    6'd42: data_len[23:16]   <= in_byte;
                    6'd43: data_len[31:24]   <= in_byte;
                    default: ;
                endcase
            end
            if (hdr_last) begin
                hdr_err <= (state_nx == ERR);
                hdr_ok  <= (state_nx != ERR);
            end
            if (state != DONE && state_nx == DONE)
                done <= 1'b1;
            if (dat_byte) begin
                data_cnt <= data_cnt + 32'd1;
                byte_idx <= samp_last ? 2'd0 : byte_idx + 2'd1;
                samp_lo  <= samp_full[23:0];
            end
            if (xfer)
                out_valid <= 1'b0;
            // A completing sample loads if the slot is free or frees this edge.
            if (samp_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= out_val;
                    out_ch    <= ch_cnt;
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
                ch_cnt <= (16'(ch_cnt) == num_ch - 16'd1) ? '0 : ch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wav_stream_packer.sv
// Directed bench: one 32-bit and one 16-bit output instance share the same
// byte stream; each step checks the instance whose configuration it targets.
module tb_wav_stream_packer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        in_en = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        out_ready = 1'b1;

    logic [31:0] a_data;
    logic        a_valid;
    logic [0:0]  a_ch;
    logic [31:0] a_rate;
    logic [15:0] a_nch, a_bps;
    logic        a_ok, a_err, a_done, a_ovf;

    logic [15:0] b_data;
    logic        b_valid;
    logic [0:0]  b_ch;
    logic [31:0] b_rate;
    logic [15:0] b_nch, b_bps;
    logic        b_ok, b_err, b_done, b_ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wav_stream_packer #(.OUT_W(32), .MAX_CH(2)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .in_en(in_en), .in_byte(in_byte),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .out_ch(a_ch),
        .sample_rate(a_rate), .num_ch(a_nch), .bits_ps(a_bps),
        .hdr_ok(a_ok), .hdr_err(a_err), .done(a_done), .overflow(a_ovf)
    );

    wav_stream_packer #(.OUT_W(16), .MAX_CH(2)) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .in_en(in_en), .in_byte(in_byte),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .out_ch(b_ch),
        .sample_rate(b_rate), .num_ch(b_nch), .bits_ps(b_bps),
        .hdr_ok(b_ok), .hdr_err(b_err), .done(b_done), .overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_en   = 1'b1;
        in_byte = b;
        @(posedge clk);
        #1;
        in_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] nch, input logic [31:0] rate,
                            input logic [15:0] bps, input logic [31:0] len,
                            input logic [7:0] b8);
        logic [7:0] h [44];
        for (int i = 0; i < 44; i++) h[i] = 8'h00;
        h[0] = 8'h52; h[1] = 8'h49; h[2] = 8'h46; h[3] = 8'h46;
        h[8] = b8;    h[9] = 8'h41; h[10] = 8'h56; h[11] = 8'h45;
        h[12] = 8'h66; h[13] = 8'h6d; h[14] = 8'h74; h[15] = 8'h20;
        h[16] = 8'h10; h[20] = 8'h01;
        h[22] = nch[7:0];   h[23] = nch[15:8];
        h[24] = rate[7:0];  h[25] = rate[15:8]; h[26] = rate[23:16]; h[27] = rate[31:24];
        h[34] = bps[7:0];   h[35] = bps[15:8];
        h[36] = 8'h64; h[37] = 8'h61; h[38] = 8'h74; h[39] = 8'h61;
        h[40] = len[7:0];   h[41] = len[15:8];  h[42] = len[23:16];  h[43] = len[31:24];
        for (int i = 0; i < 44; i++) put(h[i]);
    endtask

    initial begin
        // reset values while rstn is low
        #12;
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_data", a_data, 32'h0);
        chk("rst_rate", a_rate, 32'h0);
        chk("rst_flags", {a_ok, a_err, a_done, a_ovf}, 4'b0000);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;

        // bytes in IDLE are ignored
        put(8'h52); put(8'h49);
        chk("idle_valid", a_valid, 1'b0);
        chk("idle_ok", a_ok, 1'b0);

        // 16-bit stereo 44.1 kHz, 8 data bytes
        pulse_start();
        send_hdr(16'd2, 32'd44100, 16'd16, 32'd8, 8'h57);
        chk("s16_ok", a_ok, 1'b1);
        chk("s16_rate", a_rate, 32'd44100);
        chk("s16_nch", a_nch, 16'd2);
        chk("s16_bps", a_bps, 16'd16);
        put(8'h34); put(8'h12);
        chk("s16_d0", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'h12340000});
        put(8'h78);
        chk("s16_xfer", a_valid, 1'b0);
        put(8'h56);
        chk("s16_d1", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b1, 32'h56780000});
        put(8'hBC); put(8'h9A);
        chk("s16_d2", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'h9ABC0000});
        put(8'hF0); put(8'hDE);
        chk("s16_d3", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b1, 32'hDEF00000});
        chk("s16_done", {a_done, a_ovf}, 2'b10);
        put(8'h11); put(8'h22);
        chk("s16_after_done", a_valid, 1'b0);

        // 8-bit mono, unsigned to signed
        pulse_start();
        chk("start_clear", {a_ok, a_done, a_nch}, {1'b0, 1'b0, 16'd0});
        send_hdr(16'd1, 32'd8000, 16'd8, 32'd3, 8'h57);
        put(8'h80);
        chk("u8_d0", {b_valid, 3'b0, b_ch, 16'h0, b_data}, {1'b1, 3'b0, 1'b0, 32'h0000});
        put(8'hFF);
        chk("u8_d1", {b_valid, 3'b0, b_ch, 16'h0, b_data}, {1'b1, 3'b0, 1'b0, 32'h7F00});
        chk("u8_d1_w32", a_data, 32'h7F000000);
        put(8'h00);
        chk("u8_d2", {b_valid, 3'b0, b_ch, 16'h0, b_data}, {1'b1, 3'b0, 1'b0, 32'h8000});
        chk("u8_done", b_done, 1'b1);

        // bad RIFF/WAVE tag
        pulse_start();
        send_hdr(16'd2, 32'd44100, 16'd16, 32'd8, 8'h58);
        chk("badtag_flags", {a_ok, a_err}, 2'b01);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        chk("badtag_nodata", a_valid, 1'b0);

        // 24-bit: rejected for OUT_W=16, streamed for OUT_W=32
        pulse_start();
        send_hdr(16'd1, 32'd48000, 16'd24, 32'd6, 8'h57);
        chk("b24_w16_err", {b_ok, b_err}, 2'b01);
        chk("b24_w32_ok", {a_ok, a_err}, 2'b10);
        put(8'h01); put(8'h02); put(8'h03);
        chk("b24_w32_d0", a_data, 32'h03020100);
        chk("b24_w16_nodata", b_valid, 1'b0);

        // too many channels
        pulse_start();
        send_hdr(16'd3, 32'd44100, 16'd16, 32'd8, 8'h57);
        chk("nch3_err", {a_ok, a_err}, 2'b01);

        // zero-length data
        pulse_start();
        send_hdr(16'd2, 32'd44100, 16'd16, 32'd0, 8'h57);
        chk("len0_done", {a_ok, a_done}, 2'b11);
        put(8'h01); put(8'h02);
        chk("len0_nodata", a_valid, 1'b0);

        // trailing partial sample discarded
        pulse_start();
        send_hdr(16'd1, 32'd44100, 16'd16, 32'd3, 8'h57);
        put(8'h11); put(8'h22);
        chk("trail_d0", a_data, 32'h22110000);
        put(8'h33);
        chk("trail_end", {a_valid, a_done}, 2'b01);

        // backpressure: 4 samples while out_ready=0
        pulse_start();
        send_hdr(16'd2, 32'd44100, 16'd16, 32'd20, 8'h57);
        out_ready = 1'b0;
        put(8'h11); put(8'h22);
        chk("bp_first", {a_valid, a_ovf}, 2'b10);
        put(8'h33); put(8'h44);
        chk("bp_ovf", a_ovf, 1'b1);
        put(8'h55); put(8'h66); put(8'h77); put(8'h88);
        chk("bp_hold", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'h22110000});
        out_ready = 1'b1;
        @(posedge clk) #1;
        chk("bp_release", {a_valid, a_ovf}, 2'b01);
        put(8'h99); put(8'hAA);
        chk("bp_next", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'hAA990000});
        out_ready = 1'b0;
        put(8'hBB);
        out_ready = 1'b1;
        put(8'hCC);
        chk("bp_same_cycle", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b1, 32'hCCBB0000});

        // async reset mid-DATA, then a fresh file
        pulse_start();
        send_hdr(16'd2, 32'd44100, 16'd16, 32'd8, 8'h57);
        put(8'h01); put(8'h02);
        rstn = 1'b0;
        #2;
        chk("mid_rst", {a_valid, a_ok, a_done}, 3'b000);
        chk("mid_rst_fields", {a_rate, a_nch}, {32'h0, 16'h0});
        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;
        pulse_start();
        send_hdr(16'd2, 32'd44100, 16'd16, 32'd8, 8'h57);
        put(8'h34); put(8'h12);
        chk("post_rst_d0", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'h12340000});

        // start mid-DATA with a pending sample
        out_ready = 1'b0;
        put(8'h78); put(8'h56);
        pulse_start();
        chk("mid_start", {a_valid, a_ok, a_ovf}, 3'b000);
        out_ready = 1'b1;
        send_hdr(16'd1, 32'd22050, 16'd16, 32'd4, 8'h57);
        chk("restart_rate", a_rate, 32'd22050);
        put(8'hAB); put(8'hCD);
        chk("restart_d0", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'hCDAB0000});
        put(8'hEF); put(8'h01);
        chk("restart_d1", {a_valid, 3'b0, a_ch, a_data}, {1'b1, 3'b0, 1'b0, 32'h01EF0000});
        chk("restart_done", a_done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
